// File: rtl/polinomio_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package polinomio_pkg;

  // Controller states: idle, one multiply-add per step, done pulse.
  typedef enum logic [1:0] {
    OCIOSO,
    PASSO,
    FIM
  } estado_t;

  // Bit offset of coefficient k inside the packed coefficient bus.
  function automatic int unsigned coef_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/passo_horner.sv
// One Horner step: novo_acc = acc*X + c, with full-width overflow detection
// in unsigned or two's-complement mode. Purely combinational.
module passo_horner #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] X,
  input  logic [W-1:0] c,
  input  logic         com_sinal,
  output logic [W-1:0] novo_acc,
  output logic         ovf
);

  logic [2*W-1:0] acc_ext;
  logic [2*W-1:0] x_ext;
  logic [2*W-1:0] prod;
  logic [2*W:0]   prod_ext;
  logic [2*W:0]   c_ext;
  logic [2*W:0]   soma;
  logic           ovf_prod;
  logic           ovf_soma;

  // Extend operands per mode; the low 2W bits of the product of the extended
  // operands are exact in both modes, and the 2W+1-bit sum cannot wrap.
  always_comb begin
    acc_ext  = {{W{com_sinal & acc[W-1]}}, acc};
    x_ext    = {{W{com_sinal & X[W-1]}}, X};
    prod     = acc_ext * x_ext;
    prod_ext = {com_sinal & prod[2*W-1], prod};
    c_ext    = {{(W+1){com_sinal & c[W-1]}}, c};
    soma     = prod_ext + c_ext;
    novo_acc = soma[W-1:0];
  end

  // Out of range: upper bits not a pure zero (unsigned) or sign extension (signed).
  always_comb begin
    if (com_sinal) begin
      ovf_prod = (prod[2*W-1:W-1] != '0) && (prod[2*W-1:W-1] != '1);
      ovf_soma = (soma[2*W:W-1] != '0) && (soma[2*W:W-1] != '1);
    end else begin
      ovf_prod = (prod[2*W-1:W] != '0);
      ovf_soma = (soma[2*W:W] != '0);
    end
    ovf = ovf_prod | ovf_soma;
  end

endmodule

// File: rtl/polinomio_horner.sv
// Polynomial evaluator P(X) = sum coef[k]*X^k by Horner's rule, one
// multiply-add per clock, runtime degree up to GRAU, inicio/pronto handshake.
module polinomio_horner #(
  parameter int W    = 16,
  parameter int GRAU = 2,
  parameter int GW   = (GRAU < 1) ? 1 : $clog2(GRAU + 1)
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  inicio,
  input  logic                  com_sinal,
  input  logic [GW-1:0]         grau,
  input  logic [W-1:0]          X,
  input  logic [(GRAU+1)*W-1:0] coef,
  output logic [W-1:0]          Resultado,
  output logic                  pronto,
  output logic                  ocupado,
  output logic                  overflow
);

  import polinomio_pkg::*;

  localparam int unsigned NCOEF = GRAU + 1;

  estado_t               estado;
  logic [W-1:0]          acc;
  logic [W-1:0]          x_l;
  logic [(GRAU+1)*W-1:0] coef_l;
  logic                  sinal_l;
  logic [GW-1:0]         k;
  logic                  ovf_r;
  logic                  pronto_r;
  logic                  ocupado_r;

  logic [GW-1:0]         g;
  logic [GW-1:0]         idx;
  logic [(GRAU+1)*W-1:0] coef_src;
  logic [W-1:0]          c_sel;
  logic [W-1:0]          novo_acc;
  logic                  ovf_passo;

  // Requested degree clamped to the maximum supported degree.
  always_comb begin
    g = grau;
    if (int'(grau) > GRAU) g = GW'(GRAU);
  end

  // Coefficient mux: the live bus selects coef[g] at acceptance, the latched
  // copy selects coef[k-1] while stepping; one mux serves both.
  always_comb begin
    if (estado == OCIOSO) begin
      coef_src = coef;
      idx      = g;
    end else begin
      coef_src = coef_l;
      idx      = k - GW'(1);
    end
    c_sel = '0;
    for (int unsigned i = 0; i < NCOEF; i++) begin
      if (idx == GW'(i)) c_sel = coef_src[coef_lsb(i, W) +: W];
    end
  end

  passo_horner #(.W(W)) u_passo (
    .acc      (acc),
    .X        (x_l),
    .c        (c_sel),
    .com_sinal(sinal_l),
    .novo_acc (novo_acc),
    .ovf      (ovf_passo)
  );

  // Controller: latch operands on accepted inicio, step k down to 0, pulse pronto.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      acc       <= '0;
      k         <= '0;
      x_l       <= '0;
      coef_l    <= '0;
      sinal_l   <= 1'b0;
      ovf_r     <= 1'b0;
      pronto_r  <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            x_l       <= X;
            coef_l    <= coef;
            sinal_l   <= com_sinal;
            acc       <= c_sel;
            k         <= g;
            ovf_r     <= 1'b0;
            ocupado_r <= 1'b1;
            if (g != '0) begin
              estado <= PASSO;
            end else begin
              estado   <= FIM;
              pronto_r <= 1'b1;
            end
          end
        end
        PASSO: begin
          acc   <= novo_acc;
          ovf_r <= ovf_r | ovf_passo;
          k     <= k - GW'(1);
          if (k == GW'(1)) begin
            estado   <= FIM;
            pronto_r <= 1'b1;
          end
        end
        FIM: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado    <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign Resultado = acc;
  assign pronto    = pronto_r;
  assign ocupado   = ocupado_r;
  assign overflow  = ovf_r;

endmodule
